// File: rtl/t_flip_flop_bank.sv
`default_nettype none
// ============================================================================
// Module      : t_flip_flop_bank
// Description : Bank of WIDTH synchronous toggle flip-flops. With CHAIN=0
//               every cell toggles on its own request; with CHAIN=1 each
//               cell's toggle is qualified by a synchronous carry from the
//               cells below, so the bank counts up by one per edge when all
//               toggle requests are held high.
//
// Ports       : clk        - sole clock, all state updates on rising edge
//               rst        - synchronous active-high reset (q <= RESET_VALUE)
//               t          - per-cell toggle request
//               load       - synchronous parallel load strobe
//               d          - parallel load data
//               q          - registered cell state
//               q_n        - combinational complement of q
//               toggled    - registered mask of bits changed at last edge
//               carry_out  - next edge would toggle the top cell out of 1
//
// Priority    : rst > load > toggle
//
// Revision    : 1.0 - initial release
// ============================================================================
module t_flip_flop_bank #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               CHAIN       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic [WIDTH-1:0] toggled,
    output logic             carry_out
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_toggled;

    // Effective toggle enable per cell, evaluated as if load=0 and rst=0.
    logic [WIDTH-1:0] w_te;

    // The bottom cell is never gated by a carry.
    assign w_te[0] = t[0];

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_cell
            if (CHAIN) begin : g_carry
                // A higher cell may only toggle when every cell below it is
                // both toggling and currently 1, i.e. the lower bits wrap.
                assign w_te[gi] = t[gi] & w_te[gi-1] & r_q[gi-1];
            end else begin : g_indep
                assign w_te[gi] = t[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= RESET_VALUE;
            r_toggled <= '0;
        end else if (load) begin
            r_q       <= d;
            // Report which bits the load actually changed.
            r_toggled <= r_q ^ d;
        end else begin
            r_q       <= r_q ^ w_te;
            r_toggled <= w_te;
        end
    end

    assign q       = r_q;
    assign q_n     = ~r_q;
    assign toggled = r_toggled;

    // Wrap indication is only meaningful for a pure toggle edge, so it is
    // suppressed whenever reset or load would take priority at the edge.
    assign carry_out = w_te[WIDTH-1] & r_q[WIDTH-1] & ~rst & ~load;

endmodule
`default_nettype wire

// File: tb/tb_t_flip_flop_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_t_flip_flop_bank
// Description : Self-checking bench for t_flip_flop_bank. Three instances:
//               single default cell, 4-bit chained counter, and 4-bit
//               independent bank with RESET_VALUE=4'hA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t_flip_flop_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults (WIDTH=1, CHAIN=0)
    logic       rst0, load0;
    logic [0:0] t0, d0, q0, qn0, tog0;
    logic       co0;

    // Instance 1: WIDTH=4, CHAIN=1
    logic       rst1, load1;
    logic [3:0] t1, d1, q1, qn1, tog1;
    logic       co1;

    // Instance 2: WIDTH=4, CHAIN=0, RESET_VALUE=4'hA
    logic       rst2, load2;
    logic [3:0] t2, d2, q2, qn2, tog2;
    logic       co2;

    t_flip_flop_bank u_cell (
        .clk(clk), .rst(rst0), .t(t0), .load(load0), .d(d0),
        .q(q0), .q_n(qn0), .toggled(tog0), .carry_out(co0)
    );

    t_flip_flop_bank #(.WIDTH(4), .RESET_VALUE(4'h0), .CHAIN(1'b1)) u_cnt (
        .clk(clk), .rst(rst1), .t(t1), .load(load1), .d(d1),
        .q(q1), .q_n(qn1), .toggled(tog1), .carry_out(co1)
    );

    t_flip_flop_bank #(.WIDTH(4), .RESET_VALUE(4'hA), .CHAIN(1'b0)) u_ind (
        .clk(clk), .rst(rst2), .t(t2), .load(load2), .d(d2),
        .q(q2), .q_n(qn2), .toggled(tog2), .carry_out(co2)
    );

    typedef struct {
        int         sel;      // 0 = cell, 1 = counter, 2 = independent
        logic       rst;
        logic       load;
        logic [3:0] t;
        logic [3:0] d;
        logic [3:0] exp_q;
        logic [3:0] exp_tog;
        logic       exp_co;   // carry_out after the edge, inputs still held
    } vec_t;

    vec_t vecs[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle_all();
        rst0 = 1'b0; load0 = 1'b0; t0 = '0; d0 = '0;
        rst1 = 1'b0; load1 = 1'b0; t1 = '0; d1 = '0;
        rst2 = 1'b0; load2 = 1'b0; t2 = '0; d2 = '0;
    endtask

    task automatic drive(input vec_t v);
        idle_all();
        case (v.sel)
            0: begin rst0 = v.rst; load0 = v.load; t0 = v.t[0:0]; d0 = v.d[0:0]; end
            1: begin rst1 = v.rst; load1 = v.load; t1 = v.t;      d1 = v.d;      end
            default: begin rst2 = v.rst; load2 = v.load; t2 = v.t; d2 = v.d; end
        endcase
    endtask

    task automatic check_row(input int idx, input vec_t v);
        logic [3:0] aq, aqn, atog, eqn;
        logic       aco;
        case (v.sel)
            0: begin
                aq = {3'b0, q0}; aqn = {3'b0, qn0}; atog = {3'b0, tog0}; aco = co0;
                eqn = {3'b0, ~v.exp_q[0]};
            end
            1: begin aq = q1; aqn = qn1; atog = tog1; aco = co1; eqn = ~v.exp_q; end
            default: begin aq = q2; aqn = qn2; atog = tog2; aco = co2; eqn = ~v.exp_q; end
        endcase
        chk($sformatf("row%0d q", idx),         {28'b0, aq},   {28'b0, v.exp_q});
        chk($sformatf("row%0d q_n", idx),       {28'b0, aqn},  {28'b0, eqn});
        chk($sformatf("row%0d toggled", idx),   {28'b0, atog}, {28'b0, v.exp_tog});
        chk($sformatf("row%0d carry_out", idx), {31'b0, aco},  {31'b0, v.exp_co});
    endtask

    initial begin
        // ---------------- Single cell, default parameters ----------------
        vecs.push_back('{0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0}); // reset
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1}); // q=1
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0}); // q=0
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1}); // q=1
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0}); // q=0
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1}); // q=1
        for (int k = 0; k < 3; k++)                                      // hold
            vecs.push_back('{0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0});
        vecs.push_back('{0, 1'b1, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0}); // rst wins
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1}); // q=1
        vecs.push_back('{0, 1'b0, 1'b1, 4'h1, 4'h0, 4'h0, 4'h1, 1'b0}); // load beats t
        vecs.push_back('{0, 1'b0, 1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 1'b1}); // q=1 for later

        // ---------------- Counter, WIDTH=4, CHAIN=1 ----------------------
        vecs.push_back('{1, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0});
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] nq, pq;
            nq = 4'(k % 16);
            pq = 4'((k - 1) % 16);
            vecs.push_back('{1, 1'b0, 1'b0, 4'hF, 4'h0, nq, pq ^ nq, (nq == 4'hF)});
        end
        // Chain gating: q=3, t=1011 -> only the low two cells toggle
        vecs.push_back('{1, 1'b0, 1'b1, 4'h0, 4'h3, 4'h3, 4'h2, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b0, 4'hB, 4'h0, 4'h0, 4'h3, 1'b0});
        vecs.push_back('{1, 1'b0, 1'b1, 4'h0, 4'h9, 4'h9, 4'h9, 1'b0});
        // Reset mid-operation with pending load and toggles
        vecs.push_back('{1, 1'b1, 1'b1, 4'hF, 4'h6, 4'h0, 4'h0, 1'b0});

        // ---------------- Independent, WIDTH=4, RESET_VALUE=A ------------
        vecs.push_back('{2, 1'b1, 1'b0, 4'h0, 4'h0, 4'hA, 4'h0, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b0, 4'h5, 4'h0, 4'hF, 4'h5, 1'b0});
        vecs.push_back('{2, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0});

        // Bring every instance out of its undefined power-up state
        idle_all();
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_row(i, vecs[i]);
        end

        // Cell is at q=1: a reset pulse that misses the edge changes nothing
        @(negedge clk);
        idle_all();
        rst0 = 1'b1;
        #2;
        rst0 = 1'b0;
        @(posedge clk);
        #1;
        chk("cell rst between edges q", {31'b0, q0}, 32'd1);
        chk("cell rst between edges toggled", {31'b0, tog0}, 32'd0);

        // Counter carry_out gating, evaluated combinationally between edges
        @(negedge clk);
        idle_all();
        load1 = 1'b1; d1 = 4'hF;
        @(posedge clk);
        #1;
        chk("cnt load F q", {28'b0, q1}, 32'hF);
        @(negedge clk);
        load1 = 1'b0; t1 = 4'hF;
        #1;
        chk("cnt co at 15", {31'b0, co1}, 32'd1);
        load1 = 1'b1; d1 = 4'h0;
        #1;
        chk("cnt co gated by load", {31'b0, co1}, 32'd0);
        load1 = 1'b0; rst1 = 1'b1;
        #1;
        chk("cnt co gated by rst", {31'b0, co1}, 32'd0);
        rst1 = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt wrap q", {28'b0, q1}, 32'h0);
        chk("cnt wrap toggled", {28'b0, tog1}, 32'hF);
        chk("cnt wrap q_n", {28'b0, qn1}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
